// File: rtl/axi4_rd_arbiter.sv
// Two-master round-robin arbiter for the shared AXI4 read path (AR/R).
// One master owns the path for a full AR+R transaction; a watchdog flags a hung slave.
module axi4_rd_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      s_arvalid,
   output logic [1:0]      s_arready,
   input  logic [2*AW-1:0] s_araddr,
   input  logic [15:0]     s_arlen,
   output logic [1:0]      s_rvalid,
   input  logic [1:0]      s_rready,
   output logic [DW-1:0]   s_rdata,
   output logic [1:0]      s_rresp,
   output logic            s_rlast,
   output logic            m_arvalid,
   input  logic            m_arready,
   output logic [AW-1:0]   m_araddr,
   output logic [7:0]      m_arlen,
   output logic [3:0]      m_arid,
   input  logic            m_rvalid,
   output logic            m_rready,
   input  logic [DW-1:0]   m_rdata,
   input  logic [1:0]      m_rresp,
   input  logic            m_rlast,
   output logic            busy,
   output logic            err_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

   localparam logic [TW-1:0] WDOG_MAX = TW'(TIMEOUT);

   state_t        state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_grant_q, last_grant_d;
   logic [TW-1:0] wdog_q, wdog_d;
   logic          err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wdog_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wdog_q       <= wdog_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wdog_d       = '0;
      err_d        = err_q;
      s_arready    = '0;
      s_rvalid     = '0;
      s_rdata      = '0;
      s_rresp      = '0;
      s_rlast      = 1'b0;
      m_arvalid    = 1'b0;
      m_araddr     = '0;
      m_arlen      = '0;
      m_arid       = '0;
      m_rready     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            case (s_arvalid)
               2'b01:   grant_d = 1'b0;
               2'b10:   grant_d = 1'b1;
               2'b11:   grant_d = ~last_grant_q;
               default: grant_d = grant_q;
            endcase
            if (|s_arvalid) begin
               state_d      = S_AR;
               last_grant_d = grant_d;
            end
         end
         S_AR: begin
            m_arvalid          = s_arvalid[grant_q];
            m_araddr           = grant_q ? s_araddr[2*AW-1:AW] : s_araddr[AW-1:0];
            m_arlen            = grant_q ? s_arlen[15:8] : s_arlen[7:0];
            m_arid             = {3'b000, grant_q};
            s_arready[grant_q] = m_arready;
            // A master withdrawing its request forfeits the grant without issuing an AR.
            if (!s_arvalid[grant_q])
               state_d = S_IDLE;
            else if (m_arready)
               state_d = S_R;
         end
         S_R: begin
            s_rvalid[grant_q] = m_rvalid;
            m_rready          = s_rready[grant_q];
            s_rdata           = m_rdata;
            s_rresp           = m_rresp;
            s_rlast           = m_rlast;
            if (m_rvalid && s_rready[grant_q]) begin
               if (m_rlast)
                  state_d = S_IDLE;
            end else begin
               wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + TW'(1);
               if (wdog_d == WDOG_MAX)
                  err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed self-checking bench for axi4_rd_arbiter; the bench acts as both masters and the slave.
module tb_axi4_rd_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic [1:0]      s_arvalid;
   logic [1:0]      s_arready;
   logic [2*AW-1:0] s_araddr;
   logic [15:0]     s_arlen;
   logic [1:0]      s_rvalid;
   logic [1:0]      s_rready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rlast;
   logic            m_arvalid;
   logic            m_arready;
   logic [AW-1:0]   m_araddr;
   logic [7:0]      m_arlen;
   logic [3:0]      m_arid;
   logic            m_rvalid;
   logic            m_rready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic            busy;
   logic            err_timeout;

   int checks = 0;
   int errors = 0;

   axi4_rd_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16), .TW(5)) dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .busy(busy), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset;
      rst       = 1'b1;
      s_arvalid = '0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_rready  = '0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      s_arvalid = 2'b11;
      s_rready  = 2'b11;
      m_arready = 1'b1;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      m_rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if ({busy, err_timeout, m_arvalid, m_rready, s_arready, s_rvalid, m_arid} !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b err=%b arv=%b rrdy=%b arrdy=%b rv=%b id=%h exp all 0",
                  busy, err_timeout, m_arvalid, m_rready, s_arready, s_rvalid, m_arid);
      end
      checks++;
      if (s_rdata !== '0) begin
         errors++;
         $display("FAIL reset_rdata got %h exp 0", s_rdata);
      end
      do_reset();
   endtask

   task automatic test_single;
      do_reset();
      s_araddr[31:0] = 32'h3000_0000;
      s_arlen[7:0]   = 8'd3;
      s_arvalid      = 2'b01;
      #1;
      checks++;
      if (s_arready !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got arready=%b busy=%b exp 00 0", s_arready, busy);
      end
      @(negedge clk);
      checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== 32'h3000_0000 || m_arlen !== 8'd3 || m_arid !== 4'd0) begin
         errors++;
         $display("FAIL single_ar got v=%b a=%h l=%0d id=%0d exp 1 30000000 3 0",
                  m_arvalid, m_araddr, m_arlen, m_arid);
      end
      m_arready = 1'b1;
      #1;
      checks++;
      if (s_arready !== 2'b01) begin
         errors++;
         $display("FAIL single_arready got %b exp 01", s_arready);
      end
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 2'b00;
      s_rready  = 2'b01;
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'hA000_0000 + b;
         m_rlast  = (b == 3);
         m_rresp  = (b == 3) ? 2'b10 : 2'b00;
         #1;
         checks++;
         if (s_rvalid !== 2'b01 || m_rready !== 1'b1 || s_rdata !== 32'hA000_0000 + b || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_beat%0d got rv=%b rrdy=%b d=%h busy=%b exp 01 1 %h 1",
                     b, s_rvalid, m_rready, s_rdata, busy, 32'hA000_0000 + b);
         end
         @(negedge clk);
      end
      checks++;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rresp  = 2'b00;
      #1;
      if (busy !== 1'b0 || s_rvalid !== 2'b00) begin
         errors++;
         $display("FAIL single_done got busy=%b rv=%b exp 0 00", busy, s_rvalid);
      end
   endtask

   task automatic test_last_passthrough;
      do_reset();
      s_arvalid = 2'b01;
      @(negedge clk);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 2'b00;
      s_rready  = 2'b01;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      m_rresp   = 2'b10;
      #1;
      checks++;
      if (s_rlast !== 1'b1 || s_rresp !== 2'b10) begin
         errors++;
         $display("FAIL last_resp got last=%b resp=%b exp 1 10", s_rlast, s_rresp);
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rresp  = 2'b00;
      s_rready = 2'b00;
   endtask

   task automatic test_round_robin;
      do_reset();
      s_araddr  = {32'h2000_0010, 32'h1000_0000};
      s_arlen   = {8'd0, 8'd0};
      s_arvalid = 2'b11;
      @(negedge clk);
      checks++;
      if (m_arid !== 4'd0 || m_araddr !== 32'h1000_0000) begin
         errors++;
         $display("FAIL rr_first got id=%0d a=%h exp 0 10000000", m_arid, m_araddr);
      end
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      s_rready  = 2'b11;
      #1;
      checks++;
      if (s_rvalid !== 2'b01) begin
         errors++;
         $display("FAIL rr_rvalid0 got %b exp 01", s_rvalid);
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || s_arready !== 2'b00) begin
         errors++;
         $display("FAIL rr_idle got busy=%b arready=%b exp 0 00", busy, s_arready);
      end
      @(negedge clk);
      checks++;
      if (m_arid !== 4'd1 || m_araddr !== 32'h2000_0010) begin
         errors++;
         $display("FAIL rr_second got id=%0d a=%h exp 1 20000010", m_arid, m_araddr);
      end
      m_arready = 1'b1;
      #1;
      checks++;
      if (s_arready !== 2'b10) begin
         errors++;
         $display("FAIL rr_arready1 got %b exp 10", s_arready);
      end
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 2'b00;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      #1;
      checks++;
      if (s_rvalid !== 2'b10) begin
         errors++;
         $display("FAIL rr_rvalid1 got %b exp 10", s_rvalid);
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = 2'b00;
   endtask

   task automatic test_backpressure;
      do_reset();
      s_araddr[63:32] = 32'h4000_0100;
      s_arlen[15:8]   = 8'd3;
      s_arvalid       = 2'b10;
      @(negedge clk);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 2'b00;
      s_rready  = 2'b10;
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'hB000_0000 + b;
         m_rlast  = (b == 3);
         if (b == 2) begin
            s_rready = 2'b00;
            for (int s = 0; s < 5; s++) begin
               #1;
               checks++;
               if (m_rready !== 1'b0 || s_rvalid !== 2'b10 || s_rdata !== 32'hB000_0002 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL bp_stall%0d got rrdy=%b rv=%b d=%h busy=%b exp 0 10 b0000002 1",
                           s, m_rready, s_rvalid, s_rdata, busy);
               end
               @(negedge clk);
            end
            s_rready = 2'b10;
         end
         #1;
         checks++;
         if (m_rready !== 1'b1 || s_rdata !== 32'hB000_0000 + b || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_beat%0d got rrdy=%b d=%h busy=%b exp 1 %h 1",
                     b, m_rready, s_rdata, busy, 32'hB000_0000 + b);
         end
         @(negedge clk);
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = 2'b00;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_done got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_ar_stall;
      do_reset();
      s_araddr  = {32'h5000_0040, 32'h6000_0080};
      s_arlen   = {8'd1, 8'd0};
      s_arvalid = 2'b11;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (m_arvalid !== 1'b1 || m_araddr !== 32'h6000_0080 || m_arlen !== 8'd0 || s_arready !== 2'b00) begin
            errors++;
            $display("FAIL stall%0d got v=%b a=%h l=%0d arrdy=%b exp 1 60000080 0 00",
                     c, m_arvalid, m_araddr, m_arlen, s_arready);
         end
         @(negedge clk);
      end
      m_arready = 1'b1;
      #1;
      checks++;
      if (s_arready !== 2'b01) begin
         errors++;
         $display("FAIL stall_release got %b exp 01", s_arready);
      end
      @(negedge clk);
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      s_rready  = 2'b11;
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      @(negedge clk);
      checks++;
      if (m_arid !== 4'd1 || m_arlen !== 8'd1) begin
         errors++;
         $display("FAIL stall_next got id=%0d l=%0d exp 1 1", m_arid, m_arlen);
      end
      s_arvalid = 2'b01;
      #1;
      checks++;
      if (m_arvalid !== 1'b0 || s_arready !== 2'b00) begin
         errors++;
         $display("FAIL abort_ar got v=%b arrdy=%b exp 0 00", m_arvalid, s_arready);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%b exp 0", busy);
      end
      @(negedge clk);
      checks++;
      if (m_arid !== 4'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_regrant got id=%0d busy=%b exp 0 1", m_arid, busy);
      end
      s_arvalid = 2'b00;
      @(negedge clk);
      s_rready = 2'b00;
   endtask

   task automatic test_timeout;
      do_reset();
      s_araddr[31:0] = 32'h7000_0000;
      s_arvalid      = 2'b01;
      @(negedge clk);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 2'b00;
      s_rready  = 2'b01;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (err_timeout !== (k >= 16) || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cyc%0d got err=%b busy=%b exp %b 1", k, err_timeout, busy, (k >= 16));
         end
      end
   endtask

   task automatic test_reset_mid;
      m_rvalid = 1'b1;
      m_rdata  = 32'hC0DE_0001;
      #1;
      checks++;
      if (s_rvalid !== 2'b01 || s_rdata !== 32'hC0DE_0001) begin
         errors++;
         $display("FAIL mid_pre got rv=%b d=%h exp 01 c0de0001", s_rvalid, s_rdata);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, err_timeout, m_arvalid, m_rready, s_arready, s_rvalid} !== 7'b0 || s_rdata !== '0) begin
         errors++;
         $display("FAIL mid_reset got busy=%b err=%b arv=%b rrdy=%b arrdy=%b rv=%b d=%h exp all 0",
                  busy, err_timeout, m_arvalid, m_rready, s_arready, s_rvalid, s_rdata);
      end
      @(negedge clk);
      rst       = 1'b0;
      m_rvalid  = 1'b0;
      s_araddr  = {32'h8000_0004, 32'h9000_0008};
      s_arvalid = 2'b11;
      @(negedge clk);
      checks++;
      if (m_arid !== 4'd0 || m_araddr !== 32'h9000_0008 || m_arvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_after got id=%0d a=%h v=%b exp 0 90000008 1", m_arid, m_araddr, m_arvalid);
      end
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 2'b00;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL mid_done got busy=%b err=%b exp 0 0", busy, err_timeout);
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_single();
      test_last_passthrough();
      test_round_robin();
      test_backpressure();
      test_ar_stall();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
